fetch_stage: RTL and testbench

- Consumer side of the program-counter interface.
- Reads the current PC, fetches the instruction at that address from instruction memory over a req/ack handshake, and loads the IF/ID pipeline register.
- Drives pc_write_o back to the program counter's PCWrite input: the PC advances only when the instruction at pc_i has been consumed.
- Handles downstream stalls with a one-entry skid buffer, and handles branch flushes, including while a fetch is in flight.

---
 rtl/fetch_stage.sv | 195 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage: the consumer side of the program-counter interface.
// It reads the current PC, fetches the instruction at that address over a
// req/ack handshake, and loads the IF/ID pipeline register.
//
// pc_write_o is returned to the PC's PCWrite input. The PC advances only when
// the instruction at pc_i has been consumed, either into IF/ID or into the skid
// buffer, or when a flush makes the PC load a branch target.
//
// A downstream stall that arrives together with a memory ack parks the fetched
// word in a one-entry skid buffer (state HOLD). A flush with a fetch still in
// flight waits for the stale ack while holding the old address (state DRAIN).
//
// Ports
//   clk_i, rst_i       clock and synchronous active-high reset
//   pc_i               current PC
//   pc_write_o         PCWrite; the PC loads its next value at this edge
//   imem_req_o         memory request, held until ack
//   imem_addr_o        fetch address, stable while imem_req_o=1
//   imem_ack_i         memory response; imem_data_i is valid in this cycle
//   imem_data_i        fetched instruction
//   stall_i            ID cannot accept; IF/ID holds
//   flush_i            branch taken; squash IF/ID and any in-flight fetch
//   ifid_valid_o       IF/ID holds a live instruction
//   ifid_pc_o          PC of the IF/ID instruction
//   ifid_pc_plus4_o    ifid_pc_o + 4, wrapping at 2^ADDR_W
//   ifid_instr_o       IF/ID instruction
// ----------------------------------------------------------------------------
module fetch_stage #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              pc_write_o,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [DATA_W-1:0] imem_data_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              ifid_valid_o,
   output logic [ADDR_W-1:0] ifid_pc_o,
   output logic [ADDR_W-1:0] ifid_pc_plus4_o,
   output logic [DATA_W-1:0] ifid_instr_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   // The skid buffer is occupied exactly when the FSM is in HOLD, so it needs
   // no separate valid flag.
   logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
   logic [DATA_W-1:0] skid_instr_q, skid_instr_d;

   logic              ifid_valid_q, ifid_valid_d;
   logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
   logic [ADDR_W-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
   logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;

   logic              accept;
   logic              pc_write;

   // IF/ID can take a new entry when ID is not stalling or IF/ID is empty.
   assign accept = !stall_i || !ifid_valid_q;

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      skid_pc_d       = skid_pc_q;
      skid_instr_d    = skid_instr_q;
      ifid_valid_d    = ifid_valid_q;
      ifid_pc_d       = ifid_pc_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      ifid_instr_d    = ifid_instr_q;
      pc_write        = 1'b0;
      imem_req_o      = 1'b0;
      imem_addr_o     = addr_q;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (flush_i) begin
               pc_write = 1'b1;
            end
         end

         FETCH: begin
            // pc_i is stable here because pc_write stays low until the ack.
            imem_req_o  = 1'b1;
            imem_addr_o = pc_i;
            addr_d      = pc_i;
            if (flush_i) begin
               pc_write = 1'b1;
               if (!imem_ack_i) begin
                  state_d = DRAIN;
               end
            end else if (imem_ack_i) begin
               if (accept) begin
                  ifid_valid_d    = 1'b1;
                  ifid_pc_d       = pc_i;
                  ifid_pc_plus4_d = pc_i + ADDR_W'(4);
                  ifid_instr_d    = imem_data_i;
                  pc_write        = 1'b1;
               end else begin
                  skid_pc_d    = pc_i;
                  skid_instr_d = imem_data_i;
                  state_d      = HOLD;
               end
            end else if (!(stall_i && ifid_valid_q)) begin
               ifid_valid_d = 1'b0;
            end
         end

         HOLD: begin
            if (flush_i) begin
               pc_write = 1'b1;
               state_d  = FETCH;
            end else if (!stall_i) begin
               ifid_valid_d    = 1'b1;
               ifid_pc_d       = skid_pc_q;
               ifid_pc_plus4_d = skid_pc_q + ADDR_W'(4);
               ifid_instr_d    = skid_instr_q;
               pc_write        = 1'b1;
               state_d         = FETCH;
            end
         end

         DRAIN: begin
            // The PC has already moved; keep presenting the abandoned address
            // until the memory completes it, then throw the data away.
            imem_req_o  = 1'b1;
            imem_addr_o = addr_q;
            if (flush_i) begin
               pc_write = 1'b1;
            end
            if (imem_ack_i) begin
               state_d = FETCH;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Flush overrides any load or hold of IF/ID.
      if (flush_i) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP_INSTR;
      end
   end

   // The PC must not advance while the stage is being reset.
   assign pc_write_o = pc_write && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         skid_pc_q       <= '0;
         skid_instr_q    <= NOP_INSTR;
         ifid_valid_q    <= 1'b0;
         ifid_pc_q       <= '0;
         ifid_pc_plus4_q <= '0;
         ifid_instr_q    <= NOP_INSTR;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         skid_pc_q       <= skid_pc_d;
         skid_instr_q    <= skid_instr_d;
         ifid_valid_q    <= ifid_valid_d;
         ifid_pc_q       <= ifid_pc_d;
         ifid_pc_plus4_q <= ifid_pc_plus4_d;
         ifid_instr_q    <= ifid_instr_d;
      end
   end

   assign ifid_valid_o    = ifid_valid_q;
   assign ifid_pc_o       = ifid_pc_q;
   assign ifid_pc_plus4_o = ifid_pc_plus4_q;
   assign ifid_instr_o    = ifid_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. The bench plays both the PC and the
// instruction memory by driving pc_i / imem_* straight from a vector table.
// Each vector drives inputs just after a rising edge, checks the
// combinational outputs (req, addr, pc_write) before the next edge, then checks
// the IF/ID register just after that edge.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000000;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [31:0] pc_i;
   logic        pc_write_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;
   logic        stall_i;
   logic        flush_i;
   logic        ifid_valid_o;
   logic [31:0] ifid_pc_o;
   logic [31:0] ifid_pc_plus4_o;
   logic [31:0] ifid_instr_o;

   always #5 clk = ~clk;

   fetch_stage #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .NOP_INSTR(NOP)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .pc_i           (pc_i),
      .pc_write_o     (pc_write_o),
      .imem_req_o     (imem_req_o),
      .imem_addr_o    (imem_addr_o),
      .imem_ack_i     (imem_ack_i),
      .imem_data_i    (imem_data_i),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .ifid_valid_o   (ifid_valid_o),
      .ifid_pc_o      (ifid_pc_o),
      .ifid_pc_plus4_o(ifid_pc_plus4_o),
      .ifid_instr_o   (ifid_instr_o)
   );

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        ack;
      logic [31:0] data;
      logic        stall;
      logic        flush;
      logic        chk_comb;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_pcw;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_plus4;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic add(input logic rst, input logic [31:0] pc, input logic ack,
                      input logic [31:0] data, input logic stall, input logic flush,
                      input logic chk_comb, input logic e_req, input logic [31:0] e_addr,
                      input logic e_pcw, input logic e_valid, input logic [31:0] e_pc,
                      input logic [31:0] e_plus4, input logic [31:0] e_instr);
      vec_t v;
      v.rst = rst;   v.pc = pc;       v.ack = ack;     v.data = data;
      v.stall = stall; v.flush = flush; v.chk_comb = chk_comb;
      v.e_req = e_req; v.e_addr = e_addr; v.e_pcw = e_pcw;
      v.e_valid = e_valid; v.e_pc = e_pc; v.e_plus4 = e_plus4; v.e_instr = e_instr;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [31:0] pc, input logic ack,
                        input logic [31:0] data, input logic stall, input logic flush);
      rst_i = rst; pc_i = pc; imem_ack_i = ack; imem_data_i = data;
      stall_i = stall; flush_i = flush;
   endtask

   initial begin
      //   rst pc            ack data          stl fl  cc req addr          pcw val pc            plus4         instr
      // reset and first idle cycle
      add(1, 32'h0,        0, 32'h0,        0, 0,  0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        NOP);
      add(0, 32'h0,        0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        NOP);
      // zero-wait memory, one instruction per cycle
      add(0, 32'h0,        1, 32'hA0,       0, 0,  1, 1, 32'h0,        1, 1, 32'h0,        32'h4,        32'hA0);
      add(0, 32'h4,        1, 32'hA1,       0, 0,  1, 1, 32'h4,        1, 1, 32'h4,        32'h8,        32'hA1);
      add(0, 32'h8,        1, 32'hA2,       0, 0,  1, 1, 32'h8,        1, 1, 32'h8,        32'hC,        32'hA2);
      // ack delayed: two wait cycles then ack
      add(0, 32'h10,       0, 32'h0,        0, 0,  1, 1, 32'h10,       0, 0, 32'h8,        32'hC,        32'hA2);
      add(0, 32'h10,       0, 32'h0,        0, 0,  1, 1, 32'h10,       0, 0, 32'h8,        32'hC,        32'hA2);
      add(0, 32'h10,       1, 32'hB0,       0, 0,  1, 1, 32'h10,       1, 1, 32'h10,       32'h14,       32'hB0);
      // ack while stalled -> HOLD, then release
      add(0, 32'h20,       1, 32'hC0,       1, 0,  1, 1, 32'h20,       0, 1, 32'h10,       32'h14,       32'hB0);
      add(0, 32'h20,       0, 32'h0,        1, 0,  1, 0, 32'h20,       0, 1, 32'h10,       32'h14,       32'hB0);
      add(0, 32'h20,       0, 32'h0,        0, 0,  1, 0, 32'h20,       1, 1, 32'h20,       32'h24,       32'hC0);
      // flush with fetch in flight -> DRAIN on old address
      add(0, 32'h30,       0, 32'h0,        0, 0,  1, 1, 32'h30,       0, 0, 32'h20,       32'h24,       32'hC0);
      add(0, 32'h30,       0, 32'h0,        0, 1,  1, 1, 32'h30,       1, 0, 32'h20,       32'h24,       NOP);
      add(0, 32'h100,      0, 32'h0,        0, 0,  1, 1, 32'h30,       0, 0, 32'h20,       32'h24,       NOP);
      add(0, 32'h100,      1, 32'hDEAD,     0, 0,  1, 1, 32'h30,       0, 0, 32'h20,       32'h24,       NOP);
      add(0, 32'h100,      1, 32'hD0,       0, 0,  1, 1, 32'h100,      1, 1, 32'h100,      32'h104,      32'hD0);
      // HOLD occupied, then flush and stall together
      add(0, 32'h104,      1, 32'hD1,       1, 0,  1, 1, 32'h104,      0, 1, 32'h100,      32'h104,      32'hD0);
      add(0, 32'h104,      0, 32'h0,        1, 1,  1, 0, 32'h104,      1, 0, 32'h100,      32'h104,      NOP);
      // flush coinciding with ack: data discarded, stay in FETCH
      add(0, 32'h200,      1, 32'hE0,       0, 1,  1, 1, 32'h200,      1, 0, 32'h100,      32'h104,      NOP);
      add(0, 32'h300,      1, 32'hE1,       0, 0,  1, 1, 32'h300,      1, 1, 32'h300,      32'h304,      32'hE1);
      // reset mid-fetch
      add(0, 32'h304,      0, 32'h0,        0, 0,  1, 1, 32'h304,      0, 0, 32'h300,      32'h304,      32'hE1);
      add(1, 32'h304,      0, 32'h0,        0, 0,  1, 1, 32'h304,      0, 0, 32'h0,        32'h0,        NOP);
      add(0, 32'h304,      0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        NOP);
      // PC wrap: plus4 of FFFFFFFC is 0
      add(0, 32'hFFFFFFFC, 1, 32'hF0,       0, 0,  1, 1, 32'hFFFFFFFC, 1, 1, 32'hFFFFFFFC, 32'h0,        32'hF0);
      add(0, 32'h0,        1, 32'hF1,       0, 0,  1, 1, 32'h0,        1, 1, 32'h0,        32'h4,        32'hF1);
      // stall with no ack: IF/ID holds
      add(0, 32'h4,        0, 32'h0,        1, 0,  1, 1, 32'h4,        0, 1, 32'h0,        32'h4,        32'hF1);
      // flush, then flush again while draining
      add(0, 32'h4,        0, 32'h0,        0, 1,  1, 1, 32'h4,        1, 0, 32'h0,        32'h4,        NOP);
      add(0, 32'h80,       0, 32'h0,        0, 1,  1, 1, 32'h4,        1, 0, 32'h0,        32'h4,        NOP);
      add(0, 32'h90,       1, 32'hBAD,      0, 0,  1, 1, 32'h4,        0, 0, 32'h0,        32'h4,        NOP);
      add(0, 32'h90,       1, 32'hC1,       0, 0,  1, 1, 32'h90,       1, 1, 32'h90,       32'h94,       32'hC1);
      // flush in IDLE right after reset
      add(1, 32'h94,       0, 32'h0,        0, 0,  1, 1, 32'h94,       0, 0, 32'h0,        32'h0,        NOP);
      add(0, 32'h94,       0, 32'h0,        0, 1,  1, 0, 32'h0,        1, 0, 32'h0,        32'h0,        NOP);
      add(0, 32'h8,        1, 32'hC2,       0, 0,  1, 1, 32'h8,        1, 1, 32'h8,        32'hC,        32'hC2);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].pc, vecs[i].ack, vecs[i].data, vecs[i].stall, vecs[i].flush);
         #3;
         if (vecs[i].chk_comb) begin
            check("req",  i, {31'd0, imem_req_o}, {31'd0, vecs[i].e_req});
            if (vecs[i].e_req) check("addr", i, imem_addr_o, vecs[i].e_addr);
            check("pcw",  i, {31'd0, pc_write_o}, {31'd0, vecs[i].e_pcw});
         end
         @(posedge clk);
         #1;
         check("valid", i, {31'd0, ifid_valid_o}, {31'd0, vecs[i].e_valid});
         check("ifpc",  i, ifid_pc_o, vecs[i].e_pc);
         check("plus4", i, ifid_pc_plus4_o, vecs[i].e_plus4);
         check("instr", i, ifid_instr_o, vecs[i].e_instr);
         $display("vec %0d: rst=%0b pc=%h ack=%0b stall=%0b flush=%0b -> valid=%0b ifpc=%h instr=%h",
                  i, vecs[i].rst, vecs[i].pc, vecs[i].ack, vecs[i].stall, vecs[i].flush,
                  ifid_valid_o, ifid_pc_o, ifid_instr_o);
      end

      // Hand sequence: three-cycle memory latency at pc=0x40. Request and
      // address must stay put and PCWrite stay low until the ack cycle.
      for (int c = 0; c < 3; c++) begin
         drive(0, 32'h40, 0, 32'h0, 0, 0);
         #3;
         check("lat_req",  100 + c, {31'd0, imem_req_o}, 32'd1);
         check("lat_addr", 100 + c, imem_addr_o, 32'h40);
         check("lat_pcw",  100 + c, {31'd0, pc_write_o}, 32'd0);
         @(posedge clk);
         #1;
         check("lat_valid", 100 + c, {31'd0, ifid_valid_o}, 32'd0);
         $display("lat %0d: waiting, req=%0b addr=%h", c, imem_req_o, imem_addr_o);
      end
      drive(0, 32'h40, 1, 32'h12345678, 0, 0);
      #3;
      check("lat_ack_pcw", 103, {31'd0, pc_write_o}, 32'd1);
      @(posedge clk);
      #1;
      check("lat_ack_valid", 103, {31'd0, ifid_valid_o}, 32'd1);
      check("lat_ack_pc",    103, ifid_pc_o, 32'h40);
      check("lat_ack_plus4", 103, ifid_pc_plus4_o, 32'h44);
      check("lat_ack_instr", 103, ifid_instr_o, 32'h12345678);
      $display("lat ack: ifpc=%h instr=%h", ifid_pc_o, ifid_instr_o);

      drive(0, 32'h44, 0, 32'h0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
